// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and S-box tables.
// The forward and inverse tables sit together so they are maintained together.
package aes_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 4;
  localparam int STATE_W   = WORD_W * NUM_WORDS;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } engine_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/inv_s_box.sv
// Four parallel combinational inverse S-box lookups, one per byte lane.
// Port layout mirrors the forward s_box: four byte addresses in, one word out.
module inv_s_box
  import aes_pkg::*;
(
  input  logic [7:0]        i_addr0,
  input  logic [7:0]        i_addr1,
  input  logic [7:0]        i_addr2,
  input  logic [7:0]        i_addr3,
  output logic [WORD_W-1:0] o_read_data
);

  assign o_read_data = {INV_SBOX[i_addr3], INV_SBOX[i_addr2],
                        INV_SBOX[i_addr1], INV_SBOX[i_addr0]};

endmodule

// File: rtl/inv_sub_bytes_engine.sv
// Multi-cycle InvSubBytes: captures a 128-bit state on start, substitutes one
// column per cycle through a single inv_s_box, then pulses done with the result.
module inv_sub_bytes_engine
  import aes_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [STATE_W-1:0] i_state_in,
  output logic               o_busy,
  output logic               o_done,
  output logic [STATE_W-1:0] o_state_out
);

  engine_state_e                    r_fsm;
  logic [IDX_W-1:0]                 r_idx;
  logic [NUM_WORDS-1:0][WORD_W-1:0] r_work;
  logic                             r_busy;
  logic                             r_done;
  logic [STATE_W-1:0]               r_state_out;

  logic [WORD_W-1:0]                w_sel_word;
  logic [WORD_W-1:0]                w_sub_word;
  logic [NUM_WORDS-1:0][WORD_W-1:0] w_work_next;
  logic                             w_last;

  assign w_sel_word = r_work[r_idx];
  assign w_last     = (r_idx == IDX_W'(NUM_WORDS - 1));

  inv_s_box u_inv_s_box (
    .i_addr0     (w_sel_word[7:0]),
    .i_addr1     (w_sel_word[15:8]),
    .i_addr2     (w_sel_word[23:16]),
    .i_addr3     (w_sel_word[31:24]),
    .o_read_data (w_sub_word)
  );

  // Working state with the current column replaced, so the final load into
  // state_out already contains the word substituted in the last RUN cycle.
  // NOTE: default-assign first so every path drives the whole vector; no latch.
  always_comb begin
    w_work_next        = r_work;
    w_work_next[r_idx] = w_sub_word;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  // NOTE: the working register is a handful of flops, not a RAM, so it is reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fsm       <= IDLE;
      r_idx       <= '0;
      r_work      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_state_out <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_fsm)
        IDLE: begin
          if (i_start) begin
            r_work <= i_state_in;
            r_idx  <= '0;
            r_busy <= 1'b1;
            r_fsm  <= RUN;
          end
        end
        RUN: begin
          r_work <= w_work_next;
          if (w_last) begin
            r_state_out <= w_work_next;
            r_done      <= 1'b1;
            r_fsm       <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          r_busy <= 1'b0;
          r_fsm  <= IDLE;
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_state_out = r_state_out;

endmodule

// File: tb/tb_inv_sub_bytes_engine.sv
// Directed + randomized bench for inv_sub_bytes_engine; the reference S-boxes
// are derived from GF(2^8) inversion and the affine map, not from lookup tables.
module tb_inv_sub_bytes_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] state_in;
  logic         busy;
  logic         done;
  logic [127:0] state_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  inv_sub_bytes_engine dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_state_in  (state_in),
    .o_busy      (busy),
    .o_done      (done),
    .o_state_out (state_out)
  );

  function automatic logic [7:0] xtime(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xtime(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] v, int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 8'h00;
      for (int j = 1; j < 256; j++)
        if (i != 0 && gmul(8'(i), 8'(j)) == 8'h01) c = 8'(j);
      fwd_tab[i] = c ^ rotl8(c, 1) ^ rotl8(c, 2) ^ rotl8(c, 3) ^ rotl8(c, 4) ^ 8'h63;
    end
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
  endtask

  function automatic logic [127:0] ref_inv_sub(logic [127:0] s);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = inv_tab[s[8*b +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] ref_fwd_sub(logic [127:0] s);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = fwd_tab[s[8*b +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [127:0] s, output logic [127:0] res);
    bit seen = 1'b0;
    state_in = s;
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) seen = 1'b1;
      else step();
    end
    check("done_seen", {127'b0, seen}, 128'd1);
    res = state_out;
    step();
  endtask

  initial begin
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] res;
    logic [127:0] prev;
    logic [127:0] ops [3];

    build_tables();
    rst      = 1'b1;
    start    = 1'b0;
    state_in = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_busy", {127'b0, busy}, 128'd0);
    check("reset_done", {127'b0, done}, 128'd0);
    check("reset_state_out", state_out, 128'd0);

    // All bytes 0x63: cycle-accurate busy/done window, result all zero.
    state_in = {16{8'h63}};
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("lat_busy_c%0d", c), {127'b0, busy}, {127'b0, (c <= 5)});
      check($sformatf("lat_done_c%0d", c), {127'b0, done}, {127'b0, (c == 5)});
      if (c == 5) check("lat_state_out", state_out, 128'd0);
      step();
    end

    run_op(128'd0, res);
    check("zero_in", res, {16{8'h52}});

    // Lane/word ordering; state_out must hold the previous result until done.
    prev     = res;
    state_in = {32'h63636363, 32'h63636363, 32'h63636363, 32'h16ED7C63};
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("hold_state_out_c%0d", c), state_out, prev);
      step();
    end
    check("lane_done", {127'b0, done}, 128'd1);
    check("lane_order", state_out, {96'd0, 32'hFF530100});
    step();

    // start re-asserted with a different state in cycles 2-5 is ignored.
    a = rand128();
    b = ~a;
    state_in = a;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    start    = 1'b1;
    state_in = b;
    for (int c = 2; c <= 4; c++) step();
    check("ignore_done", {127'b0, done}, 128'd1);
    check("ignore_result", state_out, ref_inv_sub(a));
    step();
    start = 1'b0;
    check("ignore_no_accept_c6", {127'b0, busy}, 128'd0);
    step();
    check("ignore_no_accept_c7", {127'b0, busy}, 128'd0);

    // start held high: accepts at edges 0, 6, 12; state_in scrambled in between.
    for (int k = 0; k < 3; k++) ops[k] = rand128();
    state_in = ops[0];
    start    = 1'b1;
    step();
    for (int c = 1; c <= 18; c++) begin
      if (c % 6 == 0 && c < 18) state_in = ops[c / 6];
      else state_in = rand128();
      if (c == 18) start = 1'b0;
      check($sformatf("hold_busy_c%0d", c), {127'b0, busy}, {127'b0, (c % 6 != 0)});
      check($sformatf("hold_done_c%0d", c), {127'b0, done}, {127'b0, (c % 6 == 5)});
      if (c % 6 == 5) check($sformatf("hold_result_%0d", c / 6), state_out, ref_inv_sub(ops[c / 6]));
      step();
    end

    // Reset in cycle 3 of RUN aborts without a done pulse.
    state_in = rand128();
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", {127'b0, busy}, 128'd0);
    check("abort_done", {127'b0, done}, 128'd0);
    check("abort_state_out", state_out, 128'd0);
    for (int c = 0; c < 6; c++) begin
      check($sformatf("abort_no_done_%0d", c), {127'b0, done}, 128'd0);
      step();
    end
    a = rand128();
    run_op(a, res);
    check("after_abort", res, ref_inv_sub(a));

    // Round trip through the forward S-box.
    for (int i = 0; i < 1000; i++) begin
      a = rand128();
      run_op(ref_fwd_sub(a), res);
      check($sformatf("roundtrip_%0d", i), res, a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
